instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter SIZE, default 64, the instruction memory depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a single-cycle pulse that requests a load.
REQ-005 SHALL have port word_count, input, 7 bits: the number of words to load, sampled on start.
REQ-006 SHALL have port byte_in, input, 8 bits: a program byte from the upstream source.
REQ-007 SHALL have port byte_valid, input, 1 bit: byte_in is valid this cycle.
REQ-008 SHALL have port byte_ready, output, 1 bit: the loader accepts byte_in this cycle.
REQ-009 SHALL have port mem_we, output, 1 bit: the write strobe to the instruction memory.
REQ-010 SHALL have port mem_addr, output, 32 bits: the word address, matching the 32-bit Addr of the instruction memory.
REQ-011 SHALL have port mem_wdata, output, 32 bits: the word to write.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress, used to hold the CPU in reset.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse at load completion.
REQ-014 SHALL have port error, output, 1 bit: a sticky flag for a rejected load request.

Function
REQ-015 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-016 SHALL, in IDLE, drive byte_ready=0, mem_we=0 and busy=0.
REQ-017 SHALL, on start in IDLE with 1<=word_count<=SIZE: latch the count, clear error, set the word index and byte index to 0, and enter RECV on the next edge.
REQ-018 SHALL, on start with word_count==0: enter DONE, perform no writes and leave error=0.
REQ-019 SHALL, on start with word_count>SIZE: set error=1, remain in IDLE and perform no writes.
REQ-020 SHALL drive byte_ready=1 only in RECV.
REQ-021 SHALL accept a byte only on a cycle where byte_valid&&byte_ready is true.
REQ-022 SHALL leave a byte unconsumed when byte_valid is high but byte_ready is low; the upstream source holds the byte.
REQ-023 SHALL assemble each word big-endian: the 1st accepted byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-024 SHALL enter WRITE on the edge at which the 4th byte is accepted.
REQ-025 SHALL, in WRITE, drive mem_we=1 for exactly one cycle, with mem_addr = word index zero-extended to 32 bits, mem_wdata = the assembled word, and byte_ready=0.
REQ-026 SHALL, after WRITE, go to DONE if word index == count-1; otherwise increment the word index, reset the byte index to 0, and return to RECV.
REQ-027 SHALL hold mem_we=0 outside WRITE, and SHALL hold mem_addr and mem_wdata stable at their last values outside WRITE.
REQ-028 SHALL, in DONE, drive done=1 for one cycle, then go to IDLE with busy=0.
REQ-029 SHALL drive busy=1 in RECV, WRITE and DONE.
REQ-030 SHALL ignore start while busy=1, leaving count and index unchanged.
REQ-031 SHALL give latency such that, with byte_valid held continuously high and start at cycle 0: bytes are accepted in cycles 1-4, the first write is in cycle 5, word k is written in cycle 5(k+1), and done is asserted in cycle 5N+1.
REQ-032 SHALL leave error set until the next accepted start or rst.

Reset
REQ-033 SHALL, on rst=1 at a rising edge, enter IDLE with byte_ready=0, mem_we=0, busy=0, done=0, error=0, mem_addr=0, mem_wdata=0, and all indices 0.
REQ-034 SHALL, on rst asserted mid-load, discard the partial word, perform no write in the following cycle, and emit no done pulse.
REQ-035 SHALL give rst priority over start and byte_valid in the same cycle.

Verification
REQ-036 SHALL cover: start with word_count=2 and bytes 44 10 80 01 44 21 00 02 sent continuously -> writes 0x44108001 at addr 0 in cycle 5 and 0x44210002 at addr 1 in cycle 10; done in cycle 11; busy high for cycles 1-11.
REQ-037 SHALL cover: word_count=1, bytes CA 60 8C 00, with byte_valid deasserted every other cycle -> a single write of 0xCA608C00 at addr 0, one cycle after the 4th accepted byte; no extra bytes consumed.
REQ-038 SHALL cover: start with word_count=65 (SIZE=64) -> error=1, busy stays 0, no mem_we; a subsequent start with word_count=1 clears error.
REQ-039 SHALL cover: start with word_count=0 -> no mem_we; done pulses in cycle 1; error=0.
REQ-040 SHALL cover: word_count=3 with rst asserted after 6 accepted bytes -> exactly 1 write has occurred; then IDLE, busy=0, no done; a fresh load then starts at addr 0.
REQ-041 SHALL cover: start re-pulsed mid-load with word_count=5 (original word_count=2) -> ignored; exactly 2 writes and done after the 2nd write.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - load request, byte stream and memory write bus of the instruction loader
interface instr_mem_loader_if;
   logic        start;
   logic [6:0]  word_count;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      output start, word_count, byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
   );

   modport slave (
      input  start, word_count, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error
   );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - assembles big-endian words from a byte stream and writes them to instruction memory
module instr_mem_loader #(
   parameter int SIZE = 64
) (
   input logic               clk,
   input logic               rst,
   instr_mem_loader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   localparam logic [7:0] SIZE_W = 8'(SIZE);

   state_t      state;
   state_t      state_next;
   logic [6:0]  count;
   logic [6:0]  word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] partial;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        error_q;
   logic        accept;
   logic        req_zero;
   logic        req_ok;
   logic        last_word;

   assign accept    = bus.byte_valid && bus.byte_ready;
   assign req_zero  = (bus.word_count == 7'd0);
   assign req_ok    = !req_zero && ({1'b0, bus.word_count} <= SIZE_W);
   assign last_word = (word_idx == count - 7'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (req_zero) begin
                  state_next = DONE;
               end else if (req_ok) begin
                  state_next = RECV;
               end
            end
         end
         RECV: begin
            if (accept && byte_idx == 2'd3) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            state_next = last_word ? DONE : RECV;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.byte_ready = (state == RECV);
      bus.mem_we     = (state == WRITE);
      bus.busy       = (state != IDLE);
      bus.done       = (state == DONE);
   end

   // Address and data are captured with the 4th byte so they stay stable after the write.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= 7'd0;
         word_idx <= 7'd0;
         byte_idx <= 2'd0;
         partial  <= 24'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         error_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (req_zero || req_ok) begin
                     count    <= bus.word_count;
                     word_idx <= 7'd0;
                     byte_idx <= 2'd0;
                     error_q  <= 1'b0;
                  end else begin
                     error_q  <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (accept) begin
                  if (byte_idx == 2'd3) begin
                     addr_q   <= {25'd0, word_idx};
                     wdata_q  <= {partial, bus.byte_in};
                     byte_idx <= 2'd0;
                  end else begin
                     partial  <= {partial[15:0], bus.byte_in};
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            WRITE: begin
               if (!last_word) begin
                  word_idx <= word_idx + 7'd1;
                  byte_idx <= 2'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.error     = error_q;

endmodule
